// File: rtl/temp_sensor_pkg.sv
// Shared constants and helpers for the SPI temperature sensor reader.
// CELSIUS_W is also the input width of the downstream Fahrenheit converter.
package temp_sensor_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned INT_MSB    = 15;
  localparam int unsigned INT_LSB    = 7;
  localparam int unsigned CELSIUS_W  = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StCsSetup = 3'd1;
  localparam state_t StShift   = 3'd2;
  localparam state_t StCsHold  = 3'd3;
  localparam state_t StUpdate  = 3'd4;

  // Integer part of a 1/128 degC two's-complement word, negatives clamped to zero.
  function automatic logic [CELSIUS_W-1:0] clamp_celsius(input logic [FRAME_BITS-1:0] word);
    return word[INT_MSB] ? '0 : word[INT_MSB-1:INT_LSB];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample timer: counts 0..PERIOD-1 and flags the wrap cycle.
module sample_tick_gen #(
  parameter int unsigned PERIOD = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [31:0] cnt_q;

  assign tick = (cnt_q == 32'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/temp_sensor_spi_reader.sv
// Periodic SPI mode-0 reader for a 16-bit temperature sensor; presents the clamped
// integer Celsius value with a one-cycle valid strobe.
module temp_sensor_spi_reader
  import temp_sensor_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned SAMPLE_PERIOD = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 spi_miso,
  output logic                 spi_cs_n,
  output logic                 spi_sclk,
  output logic [CELSIUS_W-1:0] celsius_value,
  output logic                 valid,
  output logic                 busy,
  output logic                 sensor_neg
);

  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [4:0] HalfLast = 5'(2 * FRAME_BITS - 1);

  logic                  tick;
  state_t                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [4:0]            half_q, half_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  pending_q, pending_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [CELSIUS_W-1:0]  celsius_q;
  logic                  neg_q, valid_q;
  logic                  div_last, go;

  sample_tick_gen #(
    .PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign div_last = (div_q == DivLast);
  assign go       = start | tick | pending_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;

    case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StCsSetup;
          div_d   = '0;
        end
      end
      StCsSetup: begin
        if (div_last) begin
          state_d = StShift;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShift: begin
        // Even half-periods are SCLK low; leaving one raises SCLK and samples MISO.
        if (div_last) begin
          div_d = '0;
          if (!half_q[0]) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], spi_miso};
          end
          if (half_q == HalfLast) begin
            state_d = StCsHold;
          end else begin
            half_d = half_q + 5'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StCsHold: begin
        if (div_last) begin
          state_d = StUpdate;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // One-deep request memory: anything arriving mid-frame collapses into one flag.
    if (state_q == StIdle) begin
      if (go) pending_d = 1'b0;
    end else if (start || tick) begin
      pending_d = 1'b1;
    end

    cs_n_d = !((state_d == StCsSetup) || (state_d == StShift) || (state_d == StCsHold));
    sclk_d = (state_d == StShift) && half_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      half_q    <= '0;
      shreg_q   <= '0;
      pending_q <= 1'b1;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      celsius_q <= '0;
      neg_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      valid_q   <= (state_q == StUpdate);
      if (state_q == StUpdate) begin
        celsius_q <= clamp_celsius(shreg_q);
        neg_q     <= shreg_q[INT_MSB];
      end
    end
  end

  assign spi_cs_n      = cs_n_q;
  assign spi_sclk      = sclk_q;
  assign celsius_value = celsius_q;
  assign valid         = valid_q;
  assign sensor_neg    = neg_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/temp_sensor_spi_reader.md
Name: temp_sensor_spi_reader

Overview:
Upstream stage of the Celsius-to-Fahrenheit converter. It periodically reads a 16-bit temperature word from an external SPI temperature sensor (SPI mode 0, read-only). It extracts the integer Celsius part, clamps it to an unsigned 8-bit value, and presents it as celsius_value with a one-cycle valid strobe. The thermostat compare and display logic and the Fahrenheit converter consume celsius_value directly.

Parameters:
CLK_DIV, 2..255, default 50: system-clock cycles per SCLK half-period.
SAMPLE_PERIOD, default 100_000_000: system-clock cycles between automatic conversions (32-bit counter).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request an immediate conversion (level, sampled each cycle).
spi_miso  in  1  sensor serial data out.
spi_cs_n  out  1  sensor chip select, active low.
spi_sclk  out  1  SPI clock, idles low.
celsius_value  out  8  last converted temperature, unsigned °C, 0..255.
valid  out  1  one-cycle pulse when celsius_value is updated.
busy  out  1  high while a frame is in progress (state != IDLE).
sensor_neg  out  1  high when the last reading was negative and clamped to 0.

Behaviour:
- Reset (async assert, sync release): spi_cs_n=1, spi_sclk=0, celsius_value=0, valid=0, busy=0, sensor_neg=0, state=IDLE, sample counter=0, pending=1. The first conversion therefore starts right after reset release.
- Sample timer: free-running, counts 0..SAMPLE_PERIOD-1, and emits a tick on wrap. It is never paused by busy.
- pending flag: set by a tick or by start while not in IDLE. It is cleared when a frame begins. It is one-deep: multiple requests while busy collapse into one.
- start in IDLE, a tick in IDLE, or pending in IDLE at edge T begins a frame.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> UPDATE -> IDLE.
  - IDLE: cs_n=1, sclk=0.
  - CS_SETUP: cs_n=0 from T+1; lasts CLK_DIV cycles; sclk=0.
  - SHIFT: 16 bits, MSB first. Each bit is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high. spi_miso is sampled into the shift register on the cycle sclk goes high. Exactly 16 rising SCLK edges per frame; 32*CLK_DIV cycles total.
  - CS_HOLD: sclk=0, cs_n=0, CLK_DIV cycles.
  - UPDATE: 1 cycle, cs_n=1. Outputs are registered at the end of this cycle.
- spi_cs_n is low for exactly 34*CLK_DIV cycles. valid is high in cycle T+34*CLK_DIV+2, for one cycle only.
- Data format: 16-bit two's complement, 1/128 °C per LSB. The integer part is word[15:7], a 9-bit signed value.
  - Negative (word[15]=1): celsius_value=0, sensor_neg=1.
  - Otherwise: celsius_value=word[14:7], sensor_neg=0.
  - The fraction word[6:0] is discarded (truncation toward zero for non-negative values).
- celsius_value and sensor_neg hold their values between updates and change only together with valid.
- Reset mid-frame: cs_n returns high and sclk low immediately (asynchronously). Partial data is discarded and outputs take their reset values.
- start held high continuously: back-to-back frames, each separated by exactly one IDLE cycle.

Decomposition:
- Package temp_sensor_pkg:
  - state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE);
  - FRAME_BITS=16, INT_MSB=15, INT_LSB=7;
  - CELSIUS_W=8, shared with the converter input width.
- Sub-module sample_tick_gen: parameter PERIOD; ports clk, rst_n, tick. It is the free-running timer.
- The SCLK divider and bit counter stay inline in the FSM.

Test Plan (CLK_DIV=2, SAMPLE_PERIOD=400, behavioural SPI sensor model):
- Reset then release, sensor word 0x0C80 -> first frame begins the cycle after release; celsius_value=25, valid high exactly 1 cycle at T+70, sensor_neg=0, 16 SCLK rising edges, cs_n low 68 cycles. Feeding the converter gives 77.
- Sensor word 0x7FF8 -> celsius_value=255; word 0x0CFF -> 25 (fraction truncated).
- Sensor word 0xF380 (-25 °C) -> celsius_value=0, sensor_neg=1. The next word 0x0A00 -> 20 and sensor_neg=0.
- Several start pulses and one timer tick during a frame -> exactly one extra frame, starting one IDLE cycle after the current one; no others queued.
- No start -> frames repeat every 400 cycles. valid stays 0 between frames and celsius_value is stable.
- Assert rst_n low during SHIFT (bit 8) -> cs_n=1 and sclk=0 in the same cycle, outputs at reset values. After release a fresh full 16-bit frame is read correctly.
